// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, response flag bit positions and scheduler FSM states shared by the ALU block.
package alu_pkg;
  localparam logic [3:0] OP_ADD       = 4'd1;
  localparam logic [3:0] OP_ADD_CARRY = 4'd2;
  localparam logic [3:0] OP_SUB       = 4'd3;
  localparam logic [3:0] OP_INC       = 4'd4;
  localparam logic [3:0] OP_DEC       = 4'd5;
  localparam logic [3:0] OP_AND       = 4'd6;
  localparam logic [3:0] OP_NOT       = 4'd7;
  localparam logic [3:0] OP_ROL       = 4'd8;
  localparam logic [3:0] OP_ROR       = 4'd9;
  localparam int FLAG_CARRY   = 4;
  localparam int FLAG_BORROW  = 3;
  localparam int FLAG_ZERO    = 2;
  localparam int FLAG_PARITY  = 1;
  localparam int FLAG_INVALID = 0;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu_sched_if.sv
// alu_sched_if: two-requester request bus plus the single valid/ready response channel.
interface alu_sched_if #(parameter int BUS_WIDTH = 8);
  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [7:0]             req_opcode;
  logic [2*BUS_WIDTH-1:0] req_a;
  logic [2*BUS_WIDTH-1:0] req_b;
  logic                   resp_valid;
  logic                   resp_ready;
  logic                   resp_id;
  logic [BUS_WIDTH-1:0]   resp_y;
  logic [4:0]             resp_flags;
  modport master (
    output req_valid, req_opcode, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_y, resp_flags
  );
  modport slave (
    input  req_valid, req_opcode, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_y, resp_flags
  );
endinterface

// File: rtl/alu.sv
// alu: combinational ALU; flags are {carry_out, borrow, zero, parity, invalid_op}.
module alu
  import alu_pkg::*;
#(
    parameter int BUS_WIDTH = 8
) (
    input  logic [3:0]           opcode,
    input  logic [BUS_WIDTH-1:0] a,
    input  logic [BUS_WIDTH-1:0] b,
    input  logic                 carry_in,
    output logic [BUS_WIDTH-1:0] y,
    output logic [4:0]           flags
);
    logic co, bo, inv;
    always_comb begin
        y   = '0;
        co  = 1'b0;
        bo  = 1'b0;
        inv = 1'b0;
        case (opcode)
            OP_ADD:       {co, y} = {1'b0, a} + {1'b0, b};
            OP_ADD_CARRY: {co, y} = {1'b0, a} + {1'b0, b} + (BUS_WIDTH+1)'(carry_in);
            OP_SUB:       begin y = a - b; bo = a < b; end
            OP_INC:       {co, y} = {1'b0, a} + (BUS_WIDTH+1)'(1);
            OP_DEC:       begin y = a - BUS_WIDTH'(1); bo = a == '0; end
            OP_AND:       y = a & b;
            OP_NOT:       y = ~a;
            OP_ROL:       y = {a[BUS_WIDTH-2:0], a[BUS_WIDTH-1]};
            OP_ROR:       y = {a[0], a[BUS_WIDTH-1:1]};
            default:      inv = 1'b1;
        endcase
    end
    // invalid ops report only invalid_op so a zero result is not mistaken for a real one
    assign flags = {co, bo, ~inv & ~|y, ^y, inv};
endmodule

// File: rtl/alu_rr_arb2.sv
// alu_rr_arb2: two-way round-robin grant; last remembers which requester won most recently.
module alu_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] valid,
    output logic [1:0] grant
);
    logic last;
    always_comb begin
        grant[0] = en & valid[0] & (~valid[1] | last);
        grant[1] = en & valid[1] & (~valid[0] | ~last);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) last <= 1'b1;
        else if (|grant) last <= grant[1];
endmodule

// File: rtl/alu_sched.sv
// alu_sched: arbitrates two requesters onto one ALU, keeps a carry flag per requester,
// and returns registered results over a valid/ready response channel.
module alu_sched
  import alu_pkg::*;
#(
    parameter int BUS_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_sched_if.slave bus,
    output logic [7:0] invalid_count
);
    state_t               state;
    logic [3:0]           op;
    logic [BUS_WIDTH-1:0] a, b, alu_y;
    logic                 id;
    logic [1:0]           carry_flag, grant;
    logic [4:0]           alu_flags;

    alu_rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == IDLE && rst_n),
        .valid (bus.req_valid),
        .grant (grant)
    );
    assign bus.req_ready = grant;

    alu #(.BUS_WIDTH(BUS_WIDTH)) u_alu (
        .opcode   (op),
        .a        (a),
        .b        (b),
        .carry_in (carry_flag[id]),
        .y        (alu_y),
        .flags    (alu_flags)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state          <= IDLE;
            op             <= '0;
            a              <= '0;
            b              <= '0;
            id             <= 1'b0;
            carry_flag     <= '0;
            invalid_count  <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_id    <= 1'b0;
            bus.resp_y     <= '0;
            bus.resp_flags <= '0;
        end else
            case (state)
                IDLE: if (|grant) begin
                    op    <= grant[1] ? bus.req_opcode[7:4] : bus.req_opcode[3:0];
                    a     <= grant[1] ? bus.req_a[2*BUS_WIDTH-1:BUS_WIDTH] : bus.req_a[BUS_WIDTH-1:0];
                    b     <= grant[1] ? bus.req_b[2*BUS_WIDTH-1:BUS_WIDTH] : bus.req_b[BUS_WIDTH-1:0];
                    id    <= grant[1];
                    state <= EXEC;
                end
                EXEC: begin
                    bus.resp_y     <= alu_y;
                    bus.resp_flags <= alu_flags;
                    bus.resp_id    <= id;
                    bus.resp_valid <= 1'b1;
                    // an invalid op leaves the requester's carry chain intact
                    if (!alu_flags[FLAG_INVALID]) carry_flag[id] <= alu_flags[FLAG_CARRY];
                    else if (invalid_count != 8'hFF) invalid_count <= invalid_count + 8'd1;
                    state <= RESP;
                end
                RESP: if (bus.resp_ready) begin
                    bus.resp_valid <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: directed and random transactions checked against an arithmetic model of the scheduler.
module tb_alu_sched;
    import alu_pkg::*;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] invalid_count;
    int total = 0, bad = 0;
    int carry[2];
    int inv_cnt, last, w;
    logic [1:0] v;
    logic [3:0] op[2];
    logic [7:0] ra[2], rb[2];

    alu_sched_if #(.BUS_WIDTH(8)) bus();
    alu_sched #(.BUS_WIDTH(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus.slave),
        .invalid_count (invalid_count)
    );
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input int opc, input int x, input int y_in, input int cin,
                                  output logic [7:0] y, output logic [4:0] f);
        int r;
        logic c, bo, inv;
        c = 0; bo = 0; inv = 0;
        case (opc)
            1: r = x + y_in;
            2: r = x + y_in + cin;
            3: begin r = x - y_in; bo = x < y_in; end
            4: r = x + 1;
            5: begin r = x - 1; bo = x == 0; end
            6: r = x & y_in;
            7: r = 255 - x;
            8: r = (x * 2) % 256 + x / 128;
            9: r = x / 2 + (x % 2) * 128;
            default: begin r = 0; inv = 1; end
        endcase
        c = (opc == 1 || opc == 2 || opc == 4) && r > 255;
        y = r[7:0];
        f = {c, bo, !inv && y == 0, ^y, inv};
    endfunction

    task automatic drive();
        bus.req_valid  = v;
        bus.req_opcode = {op[1], op[0]};
        bus.req_a      = {ra[1], ra[0]};
        bus.req_b      = {rb[1], rb[0]};
    endtask

    task automatic set_req(input int i, input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
        op[i] = o; ra[i] = x; rb[i] = y; v[i] = 1'b1;
        drive();
    endtask

    task automatic model_reset();
        carry[0] = 0; carry[1] = 0; inv_cnt = 0; last = 1;
    endtask

    // called at posedge+1; returns at posedge+1 after the response handshake
    task automatic serve(input int hold, output int waited);
        logic [1:0] eg;
        logic [7:0] ey;
        logic [4:0] ef;
        int g;
        waited = 0;
        bus.resp_ready = (hold == 0);
        @(negedge clk);
        while (bus.req_ready == 2'b00 && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        eg = (v == 2'b11) ? (last == 1 ? 2'b01 : 2'b10) : v;
        chk("grant", bus.req_ready, eg);
        g = eg[1];
        model(op[g], ra[g], rb[g], carry[g], ey, ef);
        if (!ef[FLAG_INVALID]) carry[g] = ef[FLAG_CARRY];
        else if (inv_cnt < 255) inv_cnt++;
        last = g;
        @(posedge clk); #1;
        v[g] = 1'b0;
        drive();
        @(negedge clk);
        chk("exec_resp_valid", bus.resp_valid, 0);
        chk("exec_req_ready", bus.req_ready, 0);
        @(negedge clk);
        chk("resp_valid", bus.resp_valid, 1);
        chk("resp_id", bus.resp_id, g);
        chk("resp_y", bus.resp_y, ey);
        chk("resp_flags", bus.resp_flags, ef);
        chk("invalid_count", invalid_count, inv_cnt);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold_valid", bus.resp_valid, 1);
            chk("hold_y", bus.resp_y, ey);
            chk("hold_flags", bus.resp_flags, ef);
            chk("hold_req_ready", bus.req_ready, 0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [3:0] o;
        model_reset();
        v = 2'b11;
        for (int i = 0; i < 2; i++) begin op[i] = OP_ADD; ra[i] = 8'd1; rb[i] = 8'd2; end
        drive();
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_id", bus.resp_id, 0);
        chk("rst_resp_y", bus.resp_y, 0);
        chk("rst_resp_flags", bus.resp_flags, 0);
        chk("rst_invalid_count", invalid_count, 0);
        v = 2'b00;
        drive();
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        set_req(0, OP_ADD, 8'd9, 8'd33);
        serve(0, w);
        chk("first_accept_wait", w, 0);

        set_req(0, OP_ADD, 8'd250, 8'd10);       serve(0, w);
        set_req(0, OP_ADD_CARRY, 8'd9, 8'd33);   serve(0, w);
        set_req(1, OP_ADD_CARRY, 8'd9, 8'd33);   serve(0, w);

        for (int p = 0; p < 3; p++) begin
            set_req(0, OP_SUB, 8'($urandom), 8'($urandom));
            set_req(1, OP_INC, 8'($urandom), 8'($urandom));
            serve(0, w);
            serve(0, w);
        end

        set_req(1, 4'd0, 8'd5, 8'd6);   serve(0, w);
        set_req(1, 4'd12, 8'd5, 8'd6);  serve(0, w);
        set_req(1, OP_ADD_CARRY, 8'd255, 8'd0); serve(0, w);
        for (int n = 0; n < 260; n++) begin
            o = 4'($urandom_range(9, 15));
            if (o == 4'd9) o = 4'd0;
            set_req($urandom_range(0, 1), o, 8'($urandom), 8'($urandom));
            serve(0, w);
        end

        set_req(0, OP_ADD, 8'd17, 8'd4);
        set_req(1, OP_AND, 8'hF0, 8'h3C);
        serve(5, w);
        serve(0, w);
        chk("next_grant_wait", w, 0);

        for (int n = 0; n < 40; n++) begin
            int m;
            m = $urandom_range(1, 3);
            for (int i = 0; i < 2; i++)
                if (m[i]) begin
                    o = ($urandom_range(0, 3) == 0) ? OP_ADD_CARRY : 4'($urandom_range(0, 15));
                    set_req(i, o, 8'($urandom), 8'($urandom));
                end
            while (v != 2'b00) serve($urandom_range(0, 2), w);
        end

        set_req(0, OP_ADD, 8'd250, 8'd10); serve(0, w);
        set_req(0, OP_SUB, 8'd65, 8'd66);
        w = 0;
        @(negedge clk);
        while (bus.req_ready == 2'b00 && w < 20) begin w++; @(negedge clk); end
        chk("sub_grant", bus.req_ready, 2'b01);
        @(posedge clk); #2;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        chk("mid_rst_req_ready", bus.req_ready, 0);
        chk("mid_rst_resp_valid", bus.resp_valid, 0);
        chk("mid_rst_resp_y", bus.resp_y, 0);
        chk("mid_rst_resp_flags", bus.resp_flags, 0);
        chk("mid_rst_invalid_count", invalid_count, 0);
        v = 2'b00;
        drive();
        #2 rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_no_resp", bus.resp_valid, 0);
        end
        @(posedge clk); #1;
        set_req(0, OP_ADD, 8'd9, 8'd33);        serve(0, w);
        set_req(0, OP_ADD_CARRY, 8'd9, 8'd33);  serve(0, w);
        set_req(0, OP_ADD_CARRY, 8'd200, 8'd99); set_req(1, OP_ADD_CARRY, 8'd1, 8'd2);
        serve(0, w);
        serve(0, w);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_sched.md
# alu_sched

Two-requester scheduler for the shared combinational ALU: it arbitrates between two requesters with round-robin, latches the winning operands, drives the ALU, and returns the registered result and flags over a valid/ready response channel. Each requester has its own carry flag, so multi-word ADD_CARRY chains from different requesters never corrupt each other. The block sits between the two datapath clients and the single ALU instance.

## Interface
- BUS_WIDTH, 8, operand/result width, passed through to the ALU.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester accept; one-hot or zero.
- req_opcode  in  2x4  opcodes, requester i in bits [4i+3:4i].
- req_a  in  2xBUS_WIDTH  operand A per requester.
- req_b  in  2xBUS_WIDTH  operand B per requester.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  1  requester that issued the result.
- resp_y  out  BUS_WIDTH  ALU result.
- resp_flags  out  5  {carry_out, borrow, zero, parity, invalid_op}.
- invalid_count  out  8  saturating count of invalid opcodes executed.

## Operation
- FSM states IDLE, EXEC, RESP. Reset state IDLE.
- IDLE: if any req_valid, grant one requester; req_ready[g]=1 that cycle (combinational from req_valid and the pointer); latch opcode, a, b, id=g; go to EXEC. No valid: stay.
- Arbitration: one valid wins alone. Both valid: winner is the requester not granted last. Pointer resets to "1 granted last", so requester 0 wins the first tie.
- EXEC: ALU driven from latched regs, carry_in = carry_flag[id]. Capture y and all five flags into response regs. Go to RESP.
- Carry update in EXEC: if invalid_op=0, carry_flag[id] <= alu carry_out. Otherwise unchanged. The other requester's flag is never touched.
- invalid_count: +1 in EXEC when invalid_op=1; holds at 255.
- RESP: resp_valid=1; outputs stable until resp_ready=1; then go to IDLE. req_ready=0 outside IDLE.
- Opcode set follows the ALU: 0 invalid, 1 ADD, 2 ADD_CARRY, 3 SUB, 4 INC, 5 DEC, 6 AND, 7 NOT, 8 ROL, 9 ROR, 10-15 invalid.

## Timing
- Reset values: req_ready=0 (forced 0 while rst_n low), resp_valid=0, resp_id=0, resp_y=0, resp_flags=0, invalid_count=0, both carry flags=0, FSM IDLE.
- Accept at edge N (IDLE cycle). EXEC runs in cycle N+1. resp_valid is high from cycle N+2.
- Minimum issue interval is 3 cycles, with resp_ready held high.
- Backpressure: RESP holds for any number of cycles. New requests wait with req_ready=0, and their payload must stay stable while valid.
- Reset mid-operation, in any state: FSM returns to IDLE at once. The in-flight op is dropped with no response, and all flags and counters are cleared.
- Withdrawing req_valid before its ready is legal. No grant occurs, and the pointer is unchanged.

## Structure
- Shared package alu_pkg holds the opcode localparams (OP_ADD..OP_ROR), the flag bit indices for resp_flags, and the FSM state encoding.
- The block instantiates the existing ALU, passing BUS_WIDTH through.
- One new sub-module is natural: alu_rr_arb2, the 2-way round-robin grant with its pointer register.

## Test plan
- Req0 ADD a=9 b=33, resp_ready=1 -> resp_valid two cycles after accept, id=0, y=42, flags carry=0 borrow=0 zero=0 parity=1 invalid=0.
- Req0 ADD 250+10 -> y=4, carry_out=1. Then req0 ADD_CARRY 9+33 -> y=43. Then req1 ADD_CARRY 9+33 -> y=42, because requester 1's flag is still 0.
- Both valid in the same cycle, held -> req0 served first, req1 second. Issue a third simultaneous pair -> req0 again, alternating.
- Req1 opcode 0, then opcode 12 -> invalid_op=1 on both responses, invalid_count=2, carry_flag[1] unchanged. Drive 260 invalid ops -> invalid_count stays at 255.
- Hold resp_ready=0 for 5 cycles with req0 pending -> resp_y/resp_flags stable, req_ready=0 throughout. Raise resp_ready -> the next grant is the following cycle.
- Assert rst_n=0 during EXEC of SUB 65-66 -> no response, all outputs 0. After release, ADD 9+33 -> y=42.
